led_code_arbiter: RTL and testbench

- Shares the single board LED among N_REQ status requesters.
- Each requester asks to flash a numeric blink code: `code` pulses, then an inter-code gap.
- A round-robin arbiter picks one requester at a time and latches its code.
- A phase sequencer then drives `led` with exact, tick-based ON/OFF/GAP timing derived from the system clock.

---
 rtl/led_code_arbiter.sv | 123 ++++++++++++
 tb/tb_led_code_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_code_arbiter.sv
// led_code_arbiter: round-robin owner of one LED that flashes each requester's blink code
module led_code_arbiter #(
    parameter int CLK_HZ    = 125000000,
    parameter int TICK_HZ   = 1000,
    parameter int ON_TICKS  = 100,
    parameter int OFF_TICKS = 300,
    parameter int GAP_TICKS = 1000,
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] code,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   done,
    output logic                   led
);
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int DW   = $clog2(DIV);
    localparam int MAXT = ON_TICKS > OFF_TICKS ? (ON_TICKS > GAP_TICKS ? ON_TICKS : GAP_TICKS)
                                               : (OFF_TICKS > GAP_TICKS ? OFF_TICKS : GAP_TICKS);
    localparam int TW   = $clog2(MAXT + 1);
    localparam int PW   = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n, sel_code;
    logic [DW-1:0]    div, div_n;
    logic [TW-1:0]    ph, ph_n, lim;
    logic [N_REQ-1:0] grant_n;
    logic             busy_n, done_n, led_n, tick, last, found;
    int               sel, idx;

    // First pending requester at or after the pointer, wrapping around
    always_comb begin
        found = 1'b0;
        sel   = 0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign sel_code = code[sel*CNT_W +: CNT_W];
    assign tick     = div == DW'(DIV - 1);
    assign lim      = state == ON  ? TW'(ON_TICKS - 1) :
                      state == OFF ? TW'(OFF_TICKS - 1) : TW'(GAP_TICKS - 1);
    assign last     = tick && ph == lim;

    always_comb begin
        state_n = state;
        grant_n = grant;
        busy_n  = busy;
        done_n  = 1'b0;
        led_n   = led;
        ptr_n   = ptr;
        cnt_n   = cnt;
        div_n   = tick ? '0 : div + DW'(1);
        ph_n    = last ? '0 : tick ? ph + TW'(1) : ph;
        case (state)
            IDLE: begin
                div_n = '0;
                ph_n  = '0;
                if (found) begin
                    grant_n = N_REQ'(1) << sel;
                    busy_n  = 1'b1;
                    cnt_n   = sel_code;
                    ptr_n   = sel == N_REQ - 1 ? '0 : PW'(sel + 1);
                    led_n   = sel_code != '0;
                    state_n = sel_code != '0 ? ON : GAP;
                end
            end
            ON: if (last) begin
                cnt_n   = cnt - CNT_W'(1);
                led_n   = 1'b0;
                state_n = cnt == CNT_W'(1) ? GAP : OFF;
            end
            OFF: if (last) begin
                led_n   = 1'b1;
                state_n = ON;
            end
            GAP: if (last) begin
                grant_n = '0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            led   <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
            div   <= '0;
            ph    <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            busy  <= busy_n;
            done  <= done_n;
            led   <= led_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            div   <= div_n;
            ph    <= ph_n;
        end
    end
endmodule

// File: tb/tb_led_code_arbiter.sv
// tb_led_code_arbiter: directed checks of arbitration, blink timing, latching and reset
module tb_led_code_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] code;
    logic [3:0]  grant;
    logic        busy, done, led;

    int checks = 0;
    int errors = 0;
    int n, rises, in_done, bad, idle, wdone;
    logic [3:0] g;
    logic drop_done, prev;
    logic led_log [0:1023];

    led_code_arbiter #(.CLK_HZ(8), .TICK_HZ(1), .ON_TICKS(1), .OFF_TICKS(2), .GAP_TICKS(3),
                       .N_REQ(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .code(code),
        .grant(grant), .busy(busy), .done(done), .led(led)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Idle negedges until a grant appears (bounded)
    task automatic wait_grant(input int limit);
        idle  = 0;
        wdone = 0;
        while (grant === 4'b0 && idle < limit) begin
            if (done) wdone++;
            idle++;
            @(negedge clk);
        end
    endtask

    // Follow one grant to its release, logging led and invariant violations
    task automatic capture();
        g = grant; n = 0; rises = 0; in_done = 0; bad = 0; prev = 1'b0;
        while (grant === g && g !== 4'b0 && n < 1000) begin
            led_log[n] = led;
            if (led && !prev) rises++;
            if (done) in_done++;
            if (!$onehot0(grant) || (led && !busy) || (busy !== (grant != 4'b0))) bad++;
            prev = led;
            n++;
            @(negedge clk);
        end
        drop_done = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        code = 16'h1111;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, busy, done, led} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0000000", {grant, busy, done, led});
        end
        rst = 1'b0;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int mism;
        do_reset();
        code = 16'h0003;
        req  = 4'b0001;
        wait_grant(10);
        checks++;
        if (idle !== 1 || grant !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant_latency got idle=%0d grant=%b expected 1 0001", idle, grant);
        end
        capture();
        checks++;
        if (n !== 80) begin errors++; $display("FAIL single_duration got %0d expected 80", n); end
        mism = 0;
        for (int i = 0; i < 80; i++)
            if (led_log[i] !== ((i < 8) || (i >= 24 && i < 32) || (i >= 48 && i < 56))) mism++;
        checks++;
        if (mism !== 0) begin errors++; $display("FAIL single_led_pattern got %0d bad cycles expected 0", mism); end
        checks++;
        if (drop_done !== 1'b1 || in_done !== 0) begin
            errors++;
            $display("FAIL single_done_at_drop got %b/%0d expected 1/0", drop_done, in_done);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL single_invariants got %0d expected 0", bad); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || grant !== 4'b0001) begin
            errors++;
            $display("FAIL single_regrant got done=%b grant=%b expected 0 0001", done, grant);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [0:4];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        code = 16'h1111;
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(10);
            checks++;
            if (grant !== exp_g[k] || idle !== 1) begin
                errors++;
                $display("FAIL rr_grant%0d got %b idle=%0d expected %b idle=1", k, grant, idle, exp_g[k]);
            end
            capture();
            checks++;
            if (n !== 32 || drop_done !== 1'b1 || bad !== 0) begin
                errors++;
                $display("FAIL rr_len%0d got %0d done=%b bad=%0d expected 32 1 0", k, n, drop_done, bad);
            end
        end
    endtask

    task automatic test_code_zero();
        do_reset();
        code = 16'h0000;
        req  = 4'b0100;
        wait_grant(10);
        checks++;
        if (grant !== 4'b0100) begin errors++; $display("FAIL zero_grant got %b expected 0100", grant); end
        req = 4'b0000;
        capture();
        checks++;
        if (n !== 24 || rises !== 0) begin
            errors++;
            $display("FAIL zero_len got %0d rises=%0d expected 24 0", n, rises);
        end
        checks++;
        if (drop_done !== 1'b1 || in_done !== 0) begin
            errors++;
            $display("FAIL zero_done got %b/%0d expected 1/0", drop_done, in_done);
        end
    endtask

    task automatic test_latch();
        do_reset();
        code = 16'h0020;
        req  = 4'b0010;
        wait_grant(10);
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL latch_grant got %b expected 0010", grant); end
        n = 0; rises = 0; prev = 1'b0;
        while (grant === 4'b0010 && n < 1000) begin
            if (led && !prev) rises++;
            prev = led;
            if (n == 3) begin
                req = 4'b0000;
                code[7:4] = 4'd5;
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 56 || rises !== 2) begin
            errors++;
            $display("FAIL latch_len got %0d rises=%0d expected 56 2", n, rises);
        end
        wait_grant(40);
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("FAIL latch_no_regrant got %b expected 0000", grant); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        code = 16'h0003;
        req  = 4'b0001;
        wait_grant(10);
        repeat (26) @(negedge clk);
        checks++;
        if (led !== 1'b1) begin errors++; $display("FAIL mid_second_on got %b expected 1", led); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({grant, busy, done, led} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b expected 0000000", {grant, busy, done, led});
        end
        rst = 1'b0;
        req = 4'b0011;
        wait_grant(10);
        checks++;
        if (grant !== 4'b0001 || idle !== 1 || wdone !== 0) begin
            errors++;
            $display("FAIL mid_regrant got %b idle=%0d dones=%0d expected 0001 1 0", grant, idle, wdone);
        end
    endtask

    task automatic test_max_code();
        do_reset();
        code = 16'h000F;
        req  = 4'b0001;
        wait_grant(10);
        req = 4'b0000;
        capture();
        checks++;
        if (n !== 368 || rises !== 15) begin
            errors++;
            $display("FAIL max_code got %0d rises=%0d expected 368 15", n, rises);
        end
        checks++;
        if (drop_done !== 1'b1 || bad !== 0) begin
            errors++;
            $display("FAIL max_done got %b bad=%0d expected 1 0", drop_done, bad);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        code = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_code_zero();
        test_latch();
        test_reset_mid();
        test_max_code();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
